// File: rtl/timer_cmp.sv
// timer_cmp: memory-mapped compare/interrupt unit driven by the free-running
// microsecond count. Raises a level IRQ when the count reaches COMPARE.
// Optional auto-reload for periodic ticks is built when TIMER_CMP_PERIODIC_EN
// is defined; otherwise PERIOD and CTRL.PERIODIC read 0 and every fire is one-shot.
module timer_cmp (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] TIME_COUNTER,
  input  logic        BUS_EN,
  input  logic        BUS_WE,
  input  logic [4:0]  BUS_ADDR,
  input  logic [31:0] BUS_WDATA,
  output logic [31:0] BUS_RDATA,
  output logic        BUS_RVALID,
  output logic        IRQ
);

  localparam logic [2:0] AddrTime    = 3'd0;
  localparam logic [2:0] AddrCompare = 3'd1;
  localparam logic [2:0] AddrPeriod  = 3'd2;
  localparam logic [2:0] AddrCtrl    = 3'd3;
  localparam logic [2:0] AddrStatus  = 3'd4;

  logic [31:0] compare_q, compare_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        armed_q, armed_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic [2:0]  addr;
  logic        wr, rd;
  logic [31:0] diff;
  logic        match, fire;
  logic        reload;
  logic [31:0] reload_cmp;
  logic [31:0] period_rd;
  logic        periodic_rd;
  logic        unused_addr;

  assign addr        = BUS_ADDR[4:2];
  assign unused_addr = ^BUS_ADDR[1:0];
  assign wr          = BUS_EN & BUS_WE;
  assign rd          = BUS_EN & ~BUS_WE;

  // Wrap-safe "reached or passed": sign bit of the modular distance.
  assign diff  = TIME_COUNTER - compare_q;
  assign match = ~diff[31];
  assign fire  = en_q & armed_q & match;

`ifdef TIMER_CMP_PERIODIC_EN
  logic [31:0] period_q, period_d;
  logic        periodic_q, periodic_d;

  // PERIOD register and PERIODIC control bit.
  always_comb begin
    period_d   = period_q;
    periodic_d = periodic_q;
    if (wr && addr == AddrPeriod) period_d   = BUS_WDATA;
    if (wr && addr == AddrCtrl)   periodic_d = BUS_WDATA[1];
  end

  // Periodic configuration state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      period_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      period_q   <= period_d;
      periodic_q <= periodic_d;
    end
  end

  // A zero period would refire forever, so it degrades to one-shot.
  assign reload      = periodic_q & (period_q != '0);
  assign reload_cmp  = compare_q + period_q;
  assign period_rd   = period_q;
  assign periodic_rd = periodic_q;
`else
  assign reload      = 1'b0;
  assign reload_cmp  = compare_q;
  assign period_rd   = '0;
  assign periodic_rd = 1'b0;
`endif

  // Next-state for compare, control, status, armed and read path.
  always_comb begin
    compare_d = compare_q;
    en_d      = en_q;
    ie_d      = ie_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    armed_d   = armed_q;
    rdata_d   = rdata_q;
    rvalid_d  = rd;

    // Hardware event first; software writes below override where they collide,
    // except status where the set must win over W1C.
    if (fire) begin
      if (reload) compare_d = reload_cmp;
      else        armed_d   = 1'b0;
    end

    if (wr) begin
      unique case (addr)
        AddrCompare: begin
          compare_d = BUS_WDATA;
          armed_d   = 1'b1;
        end
        AddrCtrl: begin
          en_d = BUS_WDATA[0];
          ie_d = BUS_WDATA[2];
          if (BUS_WDATA[0]) armed_d = 1'b1;
        end
        AddrStatus: begin
          if (BUS_WDATA[0]) pending_d = 1'b0;
          if (BUS_WDATA[1]) overrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (fire) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end

    if (rd) begin
      unique case (addr)
        AddrTime:    rdata_d = TIME_COUNTER;
        AddrCompare: rdata_d = compare_q;
        AddrPeriod:  rdata_d = period_rd;
        AddrCtrl:    rdata_d = {29'd0, ie_q, periodic_rd, en_q};
        AddrStatus:  rdata_d = {30'd0, overrun_q, pending_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      compare_q <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      armed_q   <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      compare_q <= compare_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      armed_q   <= armed_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign BUS_RDATA  = rdata_q;
  assign BUS_RVALID = rvalid_q;
  assign IRQ        = pending_q & ie_q;

endmodule
